// File: rtl/ysyx_22040750_ifu_if.sv
// Handshake bundle between the IFU and its neighbours: next-PC unit,
// instruction memory (AR/R channels) and the IF/ID pipeline slot.
// master: IFU side (drives O_*), slave: environment side (drives I_*).
interface ysyx_22040750_ifu_if;
  logic [31:0] I_dnpc;
  logic        I_dnpc_valid;
  logic        O_dnpc_ready;
  logic        I_flush;
  logic        O_imem_arvalid;
  logic        I_imem_arready;
  logic [31:0] O_imem_araddr;
  logic        I_imem_rvalid;
  logic        O_imem_rready;
  logic [31:0] I_imem_rdata;
  logic [1:0]  I_imem_rresp;
  logic        O_IF_ID_valid;
  logic        I_IF_ID_ready;
  logic [31:0] O_IF_ID_pc;
  logic [31:0] O_IF_ID_snpc;
  logic [31:0] O_IF_ID_inst;
  logic        O_IF_ID_fault;

  modport master (
    input  I_dnpc, I_dnpc_valid, I_flush, I_imem_arready, I_imem_rvalid,
           I_imem_rdata, I_imem_rresp, I_IF_ID_ready,
    output O_dnpc_ready, O_imem_arvalid, O_imem_araddr, O_imem_rready,
           O_IF_ID_valid, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, O_IF_ID_fault
  );

  modport slave (
    output I_dnpc, I_dnpc_valid, I_flush, I_imem_arready, I_imem_rvalid,
           I_imem_rdata, I_imem_rresp, I_IF_ID_ready,
    input  O_dnpc_ready, O_imem_arvalid, O_imem_araddr, O_imem_rready,
           O_IF_ID_valid, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, O_IF_ID_fault
  );
endinterface

// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, a single IF/ID
// slot, and flush handling that drains (drops) any fetch already in flight.
// Ports: I_clk, I_rst (async active-low), bus (ysyx_22040750_ifu_if.master).
module ysyx_22040750_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                      I_clk,
  input logic                      I_rst,
  ysyx_22040750_ifu_if.master      bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_IDLE} state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic              drop;
  logic              arvalid;
  logic              dnpc_ready;
  logic              slot_valid;
  logic [XLEN-1:0]   slot_pc;
  logic [XLEN-1:0]   slot_snpc;
  logic [XLEN-1:0]   slot_inst;
  logic              slot_fault;

  logic              rready_c;
  logic              ar_hs_c;
  logic              r_hs_c;
  logic              dnpc_hs_c;
  logic              load_c;
  logic              drain_c;
  logic              err_c;

  // Response is taken when it will be dropped or when the slot has room
  // (empty, or being consumed this cycle).
  assign rready_c  = (state == S_WAIT) && (drop || !slot_valid || bus.I_IF_ID_ready);
  assign ar_hs_c   = arvalid && bus.I_imem_arready;
  assign r_hs_c    = bus.I_imem_rvalid && rready_c;
  assign dnpc_hs_c = bus.I_dnpc_valid && dnpc_ready;
  assign load_c    = r_hs_c && !drop && !bus.I_flush;
  assign drain_c   = slot_valid && bus.I_IF_ID_ready;
  assign err_c     = (bus.I_imem_rresp != 2'b00);

  // Fetch FSM, PC and IF/ID slot registers.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      arvalid    <= 1'b0;
      dnpc_ready <= 1'b0;
      slot_valid <= 1'b0;
      slot_pc    <= '0;
      slot_snpc  <= '0;
      slot_inst  <= '0;
      slot_fault <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state   <= S_REQ;
          arvalid <= 1'b1;
        end
        S_REQ: begin
          // Request stays up until accepted; a flush only marks it for dropping.
          if (bus.I_flush) drop <= 1'b1;
          if (ar_hs_c) begin
            state   <= S_WAIT;
            arvalid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_hs_c) begin
            state      <= S_IDLE;
            drop       <= 1'b0;
            dnpc_ready <= 1'b1;
          end else if (bus.I_flush) begin
            drop <= 1'b1;
          end
        end
        S_IDLE: begin
          if (dnpc_hs_c) begin
            state      <= S_REQ;
            pc         <= bus.I_dnpc;
            dnpc_ready <= 1'b0;
            arvalid    <= 1'b1;
          end
        end
        default: state <= S_BOOT;
      endcase

      // Flush beats load beats drain.
      if (bus.I_flush) begin
        slot_valid <= 1'b0;
      end else if (load_c) begin
        slot_valid <= 1'b1;
        slot_pc    <= pc;
        slot_snpc  <= pc + XLEN'(4);
        slot_inst  <= err_c ? '0 : bus.I_imem_rdata;
        slot_fault <= err_c;
      end else if (drain_c) begin
        slot_valid <= 1'b0;
      end
    end
  end

  assign bus.O_dnpc_ready   = dnpc_ready;
  assign bus.O_imem_arvalid = arvalid;
  assign bus.O_imem_araddr  = pc;
  assign bus.O_imem_rready  = rready_c;
  assign bus.O_IF_ID_valid  = slot_valid;
  assign bus.O_IF_ID_pc     = slot_pc;
  assign bus.O_IF_ID_snpc   = slot_snpc;
  assign bus.O_IF_ID_inst   = slot_inst;
  assign bus.O_IF_ID_fault  = slot_fault;
endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Testbench for ysyx_22040750_ifu: directed scenarios plus a randomized run
// checked against a queue-based model of fetched instructions.
module tb_ysyx_22040750_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  logic I_clk;
  logic I_rst;
  int   checks;
  int   fails;

  ysyx_22040750_ifu_if bus ();

  ysyx_22040750_ifu #(.RESET_PC(RST_PC)) dut (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .bus   (bus)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h0000_0017;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a[4:2] == 3'b111) return 2'b10;
    if (a[4:2] == 3'b110) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step;
    @(posedge I_clk);
    @(negedge I_clk);
  endtask

  task automatic idle_inputs;
    bus.I_dnpc         = 32'h0;
    bus.I_dnpc_valid   = 1'b0;
    bus.I_flush        = 1'b0;
    bus.I_imem_arready = 1'b0;
    bus.I_imem_rvalid  = 1'b0;
    bus.I_imem_rdata   = 32'h0;
    bus.I_imem_rresp   = 2'b00;
    bus.I_IF_ID_ready  = 1'b0;
  endtask

  // Leaves the bench at a negedge with reset just released (DUT in BOOT).
  task automatic do_reset;
    @(negedge I_clk);
    idle_inputs();
    I_rst = 1'b0;
    step();
    step();
    I_rst = 1'b1;
  endtask

  task automatic wait_ar;
    int n;
    n = 0;
    while (bus.O_imem_arvalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.O_imem_arvalid !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL wait_arvalid: arvalid=%b after %0d cycles, want 1", bus.O_imem_arvalid, n);
    end
  endtask

  task automatic do_fetch(input logic [31:0] data, input logic [1:0] resp);
    wait_ar();
    bus.I_imem_arready = 1'b1;
    step();
    bus.I_imem_arready = 1'b0;
    bus.I_imem_rvalid  = 1'b1;
    bus.I_imem_rdata   = data;
    bus.I_imem_rresp   = resp;
    step();
    bus.I_imem_rvalid  = 1'b0;
  endtask

  task automatic boot_to_idle;
    do_reset();
    do_fetch(32'h0000_0513, 2'b00);
  endtask

  task automatic issue_dnpc(input logic [31:0] a);
    bus.I_dnpc       = a;
    bus.I_dnpc_valid = 1'b1;
    step();
    bus.I_dnpc_valid = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    I_rst = 1'b0;
    #22;
    checks++; if (bus.O_imem_arvalid !== 1'b0) begin fails++; $display("FAIL rst_arvalid: got %b want 0", bus.O_imem_arvalid); end
    checks++; if (bus.O_imem_rready !== 1'b0) begin fails++; $display("FAIL rst_rready: got %b want 0", bus.O_imem_rready); end
    checks++; if (bus.O_dnpc_ready !== 1'b0) begin fails++; $display("FAIL rst_dnpc_ready: got %b want 0", bus.O_dnpc_ready); end
    checks++; if (bus.O_IF_ID_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.O_IF_ID_valid); end
    checks++;
    if ({bus.O_IF_ID_pc, bus.O_IF_ID_snpc, bus.O_IF_ID_inst, bus.O_IF_ID_fault} !== 97'h0) begin
      fails++;
      $display("FAIL rst_payload: pc=%h snpc=%h inst=%h fault=%b want all 0",
               bus.O_IF_ID_pc, bus.O_IF_ID_snpc, bus.O_IF_ID_inst, bus.O_IF_ID_fault);
    end
    checks++; if (bus.O_imem_araddr !== RST_PC) begin fails++; $display("FAIL rst_araddr: got %h want %h", bus.O_imem_araddr, RST_PC); end
  endtask

  task automatic test_boot;
    do_reset();
    step();
    checks++; if (bus.O_imem_arvalid !== 1'b1) begin fails++; $display("FAIL boot_arvalid: got %b want 1", bus.O_imem_arvalid); end
    checks++; if (bus.O_imem_araddr !== 32'h8000_0000) begin fails++; $display("FAIL boot_araddr: got %h want 80000000", bus.O_imem_araddr); end
    bus.I_imem_arready = 1'b1;
    step();
    bus.I_imem_arready = 1'b0;
    bus.I_imem_rvalid  = 1'b1;
    bus.I_imem_rdata   = 32'h0000_0513;
    #1;
    checks++; if (bus.O_imem_rready !== 1'b1) begin fails++; $display("FAIL boot_rready: got %b want 1", bus.O_imem_rready); end
    step();
    bus.I_imem_rvalid = 1'b0;
    checks++;
    if (bus.O_IF_ID_valid !== 1'b1 || bus.O_IF_ID_pc !== 32'h8000_0000 || bus.O_IF_ID_snpc !== 32'h8000_0004 ||
        bus.O_IF_ID_inst !== 32'h0000_0513 || bus.O_IF_ID_fault !== 1'b0) begin
      fails++;
      $display("FAIL boot_slot: v=%b pc=%h snpc=%h inst=%h f=%b want 1/80000000/80000004/00000513/0",
               bus.O_IF_ID_valid, bus.O_IF_ID_pc, bus.O_IF_ID_snpc, bus.O_IF_ID_inst, bus.O_IF_ID_fault);
    end
    checks++; if (bus.O_dnpc_ready !== 1'b1) begin fails++; $display("FAIL boot_idle_dnpc_ready: got %b want 1", bus.O_dnpc_ready); end
  endtask

  task automatic test_backpressure;
    boot_to_idle();
    issue_dnpc(32'h8000_0004);
    checks++; if (bus.O_imem_araddr !== 32'h8000_0004) begin fails++; $display("FAIL bp_araddr: got %h want 80000004", bus.O_imem_araddr); end
    bus.I_imem_arready = 1'b1;
    step();
    bus.I_imem_arready = 1'b0;
    bus.I_imem_rvalid  = 1'b1;
    bus.I_imem_rdata   = 32'h0010_0093;
    #1;
    checks++; if (bus.O_imem_rready !== 1'b0) begin fails++; $display("FAIL bp_rready_held: got %b want 0", bus.O_imem_rready); end
    step();
    checks++;
    if (bus.O_IF_ID_valid !== 1'b1 || bus.O_IF_ID_pc !== 32'h8000_0000 || bus.O_IF_ID_inst !== 32'h0000_0513) begin
      fails++;
      $display("FAIL bp_slot_hold: v=%b pc=%h inst=%h want 1/80000000/00000513",
               bus.O_IF_ID_valid, bus.O_IF_ID_pc, bus.O_IF_ID_inst);
    end
    bus.I_IF_ID_ready = 1'b1;
    #1;
    checks++; if (bus.O_imem_rready !== 1'b1) begin fails++; $display("FAIL bp_rready_release: got %b want 1", bus.O_imem_rready); end
    step();
    bus.I_imem_rvalid = 1'b0;
    bus.I_IF_ID_ready = 1'b0;
    checks++;
    if (bus.O_IF_ID_valid !== 1'b1 || bus.O_IF_ID_pc !== 32'h8000_0004 || bus.O_IF_ID_snpc !== 32'h8000_0008 ||
        bus.O_IF_ID_inst !== 32'h0010_0093) begin
      fails++;
      $display("FAIL bp_slot_new: v=%b pc=%h snpc=%h inst=%h want 1/80000004/80000008/00100093",
               bus.O_IF_ID_valid, bus.O_IF_ID_pc, bus.O_IF_ID_snpc, bus.O_IF_ID_inst);
    end
  endtask

  task automatic test_flush_wait;
    boot_to_idle();
    issue_dnpc(32'h8000_0008);
    bus.I_imem_arready = 1'b1;
    step();
    bus.I_imem_arready = 1'b0;
    bus.I_flush = 1'b1;
    step();
    bus.I_flush       = 1'b0;
    bus.I_imem_rvalid = 1'b1;
    bus.I_imem_rdata  = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.O_imem_rready !== 1'b1) begin fails++; $display("FAIL flush_rready: got %b want 1", bus.O_imem_rready); end
    step();
    bus.I_imem_rvalid = 1'b0;
    checks++; if (bus.O_IF_ID_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", bus.O_IF_ID_valid); end
    checks++; if (bus.O_dnpc_ready !== 1'b1) begin fails++; $display("FAIL flush_idle: dnpc_ready=%b want 1", bus.O_dnpc_ready); end
    checks++; if (bus.O_imem_arvalid !== 1'b0) begin fails++; $display("FAIL flush_arvalid: got %b want 0", bus.O_imem_arvalid); end
  endtask

  task automatic test_redirect;
    boot_to_idle();
    bus.I_flush = 1'b1;
    issue_dnpc(32'h8000_0100);
    bus.I_flush = 1'b0;
    checks++; if (bus.O_IF_ID_valid !== 1'b0) begin fails++; $display("FAIL redir_valid: got %b want 0", bus.O_IF_ID_valid); end
    checks++;
    if (bus.O_imem_arvalid !== 1'b1 || bus.O_imem_araddr !== 32'h8000_0100) begin
      fails++;
      $display("FAIL redir_req: arvalid=%b araddr=%h want 1/80000100", bus.O_imem_arvalid, bus.O_imem_araddr);
    end
  endtask

  task automatic test_error_wrap;
    boot_to_idle();
    issue_dnpc(32'hFFFF_FFFC);
    bus.I_IF_ID_ready = 1'b1;
    do_fetch(32'h1234_5678, 2'b10);
    bus.I_IF_ID_ready = 1'b0;
    checks++;
    if (bus.O_IF_ID_valid !== 1'b1 || bus.O_IF_ID_pc !== 32'hFFFF_FFFC || bus.O_IF_ID_snpc !== 32'h0 ||
        bus.O_IF_ID_inst !== 32'h0 || bus.O_IF_ID_fault !== 1'b1) begin
      fails++;
      $display("FAIL err_wrap: v=%b pc=%h snpc=%h inst=%h f=%b want 1/fffffffc/00000000/00000000/1",
               bus.O_IF_ID_valid, bus.O_IF_ID_pc, bus.O_IF_ID_snpc, bus.O_IF_ID_inst, bus.O_IF_ID_fault);
    end
  endtask

  task automatic test_async_reset;
    boot_to_idle();
    issue_dnpc(32'h8000_0010);
    #2;
    I_rst = 1'b0;
    #1;
    checks++; if (bus.O_imem_arvalid !== 1'b0) begin fails++; $display("FAIL arst_arvalid: got %b want 0", bus.O_imem_arvalid); end
    checks++; if (bus.O_IF_ID_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b want 0", bus.O_IF_ID_valid); end
    @(negedge I_clk);
    I_rst = 1'b1;
    step();
    checks++;
    if (bus.O_imem_arvalid !== 1'b1 || bus.O_imem_araddr !== RST_PC) begin
      fails++;
      $display("FAIL arst_restart: arvalid=%b araddr=%h want 1/%h", bus.O_imem_arvalid, bus.O_imem_araddr, RST_PC);
    end
  endtask

  // Random traffic. Model: a queue of instructions that should appear in the
  // slot in order; a flush empties it and discards any fetch in flight.
  task automatic test_random;
    ent_t        expq[$];
    ent_t        e;
    ent_t        got;
    logic [31:0] exp_addr;
    logic [31:0] r;
    bit          in_flight;
    bit          pending;
    bit          discard;
    bit          r_hs;
    int          delay;
    int          done;
    do_reset();
    exp_addr  = RST_PC;
    in_flight = 1'b1;
    pending   = 1'b0;
    discard   = 1'b0;
    delay     = 0;
    done      = 0;
    for (int cyc = 0; cyc < 4000 && done < 60; cyc++) begin
      r = $urandom;
      bus.I_dnpc         = {r[31:2], 2'b00};
      bus.I_dnpc_valid   = ($urandom % 3) != 0;
      bus.I_imem_arready = ($urandom % 2) != 0;
      bus.I_IF_ID_ready  = ($urandom % 2) != 0;
      bus.I_flush        = ($urandom % 12) == 0;
      bus.I_imem_rvalid  = pending && (delay == 0);
      bus.I_imem_rdata   = bus.I_imem_rvalid ? inst_of(exp_addr) : $urandom;
      bus.I_imem_rresp   = bus.I_imem_rvalid ? resp_of(exp_addr) : 2'b00;
      #1;
      checks++;
      if (bus.O_dnpc_ready !== !in_flight || (bus.O_imem_arvalid === 1'b1 && (pending || !in_flight))) begin
        fails++;
        $display("FAIL rnd_ctrl: dnpc_ready=%b arvalid=%b in_flight=%b pending=%b",
                 bus.O_dnpc_ready, bus.O_imem_arvalid, in_flight, pending);
      end
      r_hs = bus.I_imem_rvalid && bus.O_imem_rready;
      if (bus.I_flush) begin
        expq.delete();
      end else if (bus.O_IF_ID_valid && bus.I_IF_ID_ready) begin
        checks++;
        got.pc = bus.O_IF_ID_pc; got.inst = bus.O_IF_ID_inst; got.fault = bus.O_IF_ID_fault;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL rnd_slot: unexpected slot pc=%h inst=%h", got.pc, got.inst);
        end else begin
          e = expq.pop_front();
          if (got.pc !== e.pc || got.inst !== e.inst || got.fault !== e.fault ||
              bus.O_IF_ID_snpc !== e.pc + 32'd4) begin
            fails++;
            $display("FAIL rnd_slot: pc=%h snpc=%h inst=%h f=%b want %h/%h/%h/%b",
                     got.pc, bus.O_IF_ID_snpc, got.inst, got.fault, e.pc, e.pc + 32'd4, e.inst, e.fault);
          end
        end
      end
      if (bus.O_imem_arvalid && bus.I_imem_arready) begin
        checks++;
        if (bus.O_imem_araddr !== exp_addr) begin
          fails++;
          $display("FAIL rnd_araddr: got %h want %h", bus.O_imem_araddr, exp_addr);
        end
        pending = 1'b1;
        delay   = $urandom % 3;
      end else if (r_hs) begin
        pending   = 1'b0;
        in_flight = 1'b0;
        if (!(discard || bus.I_flush)) begin
          e.pc    = exp_addr;
          e.fault = resp_of(exp_addr) != 2'b00;
          e.inst  = e.fault ? 32'h0 : inst_of(exp_addr);
          expq.push_back(e);
        end
        discard = 1'b0;
        done++;
      end else if (pending && delay > 0) begin
        delay--;
      end
      if (bus.I_flush && in_flight) discard = 1'b1;
      if (bus.I_dnpc_valid && bus.O_dnpc_ready) begin
        exp_addr  = bus.I_dnpc;
        in_flight = 1'b1;
      end
      step();
    end
    checks++;
    if (done < 60) begin
      fails++;
      $display("FAIL rnd_progress: %0d fetches completed, want 60", done);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_boot();
    test_backpressure();
    test_flush_wait();
    test_redirect();
    test_error_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22040750_ifu.md
YSYX_22040750_IFU -- requirements
Module: ysyx_22040750_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- I_clk  in  1  sole clock; all state updates on the rising edge.
- I_rst  in  1  reset; asynchronous, active-low.
- I_dnpc  in  32  next PC from the next-PC unit.
- I_dnpc_valid  in  1  I_dnpc valid.
- O_dnpc_ready  out  1  IFU accepts I_dnpc.
- I_flush  in  1  kill the IF/ID slot and any in-flight fetch.
- O_imem_arvalid  out  1  fetch request valid.
- I_imem_arready  in  1  memory accepts the request.
- O_imem_araddr  out  32  fetch address.
- I_imem_rvalid  in  1  fetch response valid.
- O_imem_rready  out  1  IFU accepts the response.
- I_imem_rdata  in  32  instruction word.
- I_imem_rresp  in  2  response status; nonzero means error.
- O_IF_ID_valid  out  1  IF/ID slot holds an instruction.
- I_IF_ID_ready  in  1  decode consumes the slot.
- O_IF_ID_pc  out  32  PC of the slot instruction.
- O_IF_ID_snpc  out  32  O_IF_ID_pc + 4.
- O_IF_ID_inst  out  32  instruction word.
- O_IF_ID_fault  out  1  fetch returned an error response.

Function
REQ-003 SHALL implement FSM states BOOT, REQ, WAIT and IDLE, with the state held in a register.
REQ-004 SHALL apply these transitions:
- BOOT->REQ unconditionally.
- REQ->WAIT on arvalid&&arready.
- WAIT->IDLE on rvalid&&rready.
- IDLE->REQ on I_dnpc_valid&&O_dnpc_ready.
- All other cases hold the current state.
REQ-005 SHALL drive O_imem_arvalid=1 only in REQ and hold it, with O_imem_araddr stable, until arready, even if I_flush asserts.
REQ-006 SHALL drive O_imem_araddr from the PC register, which loads RESET_PC at reset and I_dnpc on the dnpc handshake.
REQ-007 SHALL drive O_dnpc_ready=1 only in IDLE.
REQ-008 SHALL drive O_imem_rready=1 in WAIT when drop=1, or when O_IF_ID_valid=0, or when I_IF_ID_ready=1; otherwise 0.
REQ-009 SHALL on a non-dropped response handshake load the slot: valid=1, pc=PC, snpc=PC+4 (mod 2^32), inst=rdata, fault=(rresp!=0).
REQ-010 SHALL force inst=32'h0 when rresp!=0.
REQ-011 SHALL clear O_IF_ID_valid on I_IF_ID_ready&&O_IF_ID_valid when no load occurs in the same cycle.
REQ-012 SHALL, on a simultaneous drain and load, keep valid=1 and present the new data.
REQ-013 SHALL hold the slot payload unchanged while O_IF_ID_valid=1 and I_IF_ID_ready=0.
REQ-014 SHALL, on I_flush, clear O_IF_ID_valid next cycle; flush takes priority over load and drain.
REQ-015 SHALL, on I_flush while in REQ (before arready) or in WAIT, set drop=1.
REQ-016 SHALL, while drop=1, handshake the pending response, discard it, clear drop and go to IDLE.
REQ-017 SHALL, on I_flush coincident with a response handshake, discard that response.
REQ-018 SHALL accept a dnpc handshake coincident with I_flush (the redirect) and load the PC normally.
REQ-019 SHALL keep at most one fetch outstanding.
REQ-020 SHALL meet this latency: dnpc handshake at cycle N gives arvalid at N+1; arready at N+1 with rvalid at N+2 gives O_IF_ID_valid at N+3.

Reset
REQ-021 SHALL, while I_rst=0, asynchronously force:
- state=BOOT, PC=RESET_PC, drop=0.
- O_IF_ID_valid=0, O_IF_ID_pc/snpc/inst=0, O_IF_ID_fault=0.
- O_imem_arvalid=0, O_imem_rready=0, O_dnpc_ready=0.
REQ-022 SHALL, on reset asserted mid-transaction, abandon the transaction; after release it restarts from BOOT, and any stale response is the bench's responsibility to suppress.

Verification
REQ-023 Boot: release reset, arready=1, rvalid one cycle later with rdata=32'h00000513 -> araddr=32'h8000_0000; slot pc=32'h8000_0000, snpc=32'h8000_0004, inst=32'h00000513, fault=0.
REQ-024 Backpressure: slot full, I_IF_ID_ready=0, rvalid=1 -> rready=0 and slot unchanged; raise ready -> rready=1 same cycle, new instruction loaded next cycle, valid stays 1.
REQ-025 Flush in WAIT: flush one cycle before rvalid with rdata=32'hDEADBEEF -> response consumed, O_IF_ID_valid stays 0, state IDLE, O_dnpc_ready=1.
REQ-026 Redirect: in IDLE, I_dnpc=32'h8000_0100 with valid and I_flush both high -> next araddr=32'h8000_0100, old slot cleared.
REQ-027 Error and wrap: PC=32'hFFFF_FFFC, rresp=2'b10 -> fault=1, inst=0, snpc=32'h0000_0000.
REQ-028 Async reset: assert I_rst=0 mid-REQ between clock edges -> arvalid=0 and O_IF_ID_valid=0 immediately, without waiting for a clock edge.
